skipring_mon: RTL

- Receive-side monitor for a rotating-mask clock-skip generator.
- Each enabled cycle it takes one PULSE sample (1 = clock pulse delivered, 0 = pulse swallowed) and recovers the periodic LEN-cycle skip pattern.
- It locks onto the pattern, then reports the recovered mask, the phase, per-cycle mismatches and loss of lock.
- Sits in the iCLK domain beside the gated-clock consumer; software or a test harness uses it to confirm the programmed skip pattern.

---
 rtl/skipring_mon.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/skipring_mon.sv
// skipring_mon: receive-side monitor for a rotating-mask clock-skip generator.
// Each enabled cycle one PULSE sample is taken (1 = pulse delivered, 0 = swallowed).
// The monitor recovers the periodic LEN-cycle skip pattern, locks onto it, and reports
// the recovered mask, phase, per-cycle mismatches and loss of lock.
// Optional feature: define SKIPRING_MON_STICKY_EN to add oSTICKY, one bit per period
// position that records any mismatch seen there while locked.
// Timing: E/PULSE are sampled into a register stage at edge n. That sample is processed
// at edge n+1. There is no handshake; E alone qualifies each sample.
module skipring_mon #(
    parameter int LEN      = 16,
    parameter int VERIFY_N = 2,
    parameter int LOSS_N   = 4,
    parameter int CNT_W    = 16,
    localparam int PW = $clog2(LEN),
    localparam int SW = $clog2(LEN + 1)
) (
    input  logic             iCLK,
    input  logic             nRST,
    input  logic             E,
    input  logic             PULSE,
    input  logic             CLR,
    output logic [LEN-1:0]   oMASK,
    output logic [PW-1:0]    oPHASE,
    output logic             oLOCK,
    output logic             oERR,
    output logic [CNT_W-1:0] oERRCNT,
`ifdef SKIPRING_MON_STICKY_EN
    output logic [LEN-1:0]   oSTICKY,
`endif
    output logic [SW-1:0]    oSKIPS
);

    localparam int VW = $clog2(VERIFY_N + 1);
    localparam int LW = $clog2(LOSS_N + 1);
    localparam logic [PW-1:0] LAST  = PW'(LEN - 1);
    localparam logic [VW-1:0] VDONE = VW'(VERIFY_N);
    localparam logic [LW-1:0] LDONE = LW'(LOSS_N);

    typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

    state_t            state, state_nx;
    logic              en_r, skip_r;
    logic [LEN-1:0]    sh, sh_nx;
    logic [LEN-1:0]    ref_pat, ref_nx;
    logic [SW-1:0]     skips, skips_nx;
    logic [PW-1:0]     pos, pos_nx;
    logic [PW-1:0]     fill, fill_nx;
    logic [PW-1:0]     phase, phase_nx;
    logic [VW-1:0]     vcnt, vcnt_nx;
    logic [LW-1:0]     lcnt, lcnt_nx;
    logic              bad, bad_nx;
    logic              err, err_nx;
    logic [CNT_W-1:0]  errcnt, errcnt_nx;
    logic              mism, last;
`ifdef SKIPRING_MON_STICKY_EN
    logic [LEN-1:0]    sticky, sticky_nx;
`endif

    function automatic logic [SW-1:0] popcnt(input logic [LEN-1:0] v);
        logic [SW-1:0] c;
        c = '0;
        for (int i = 0; i < LEN; i++) c = c + SW'(v[i]);
        return c;
    endfunction

    // Input stage: register the enable and the skip flag (inverted pulse).
    always_ff @(posedge iCLK or negedge nRST) begin
        if (!nRST) begin
            en_r   <= 1'b0;
            skip_r <= 1'b0;
        end else begin
            en_r   <= E;
            skip_r <= ~PULSE;
        end
    end

    // Next-state logic: clear has priority, otherwise only enabled samples advance state.
    always_comb begin
        state_nx  = state;
        sh_nx     = sh;
        ref_nx    = ref_pat;
        skips_nx  = skips;
        pos_nx    = pos;
        fill_nx   = fill;
        phase_nx  = phase;
        vcnt_nx   = vcnt;
        lcnt_nx   = lcnt;
        bad_nx    = bad;
        err_nx    = 1'b0;
        errcnt_nx = errcnt;
        mism      = 1'b0;
        last      = (pos == LAST);
`ifdef SKIPRING_MON_STICKY_EN
        sticky_nx = sticky;
`endif
        if (CLR) begin
            state_nx  = HUNT;
            errcnt_nx = '0;
            fill_nx   = '0;
            vcnt_nx   = '0;
            lcnt_nx   = '0;
            pos_nx    = '0;
            bad_nx    = 1'b0;
`ifdef SKIPRING_MON_STICKY_EN
            sticky_nx = '0;
`endif
        end else if (en_r) begin
            sh_nx    = {skip_r, sh[LEN-1:1]};
            phase_nx = pos;
            pos_nx   = last ? '0 : pos + PW'(1);
            unique case (state)
                HUNT: begin
                    if (fill == LAST) begin
                        // First full period captured; it becomes the reference.
                        fill_nx  = '0;
                        ref_nx   = sh_nx;
                        skips_nx = popcnt(sh_nx);
                        vcnt_nx  = VW'(1);
                        lcnt_nx  = '0;
                        bad_nx   = 1'b0;
                        state_nx = (VERIFY_N == 1) ? LOCKED : VERIFY;
                    end else begin
                        fill_nx = fill + PW'(1);
                    end
                end
                VERIFY: begin
                    if (last) begin
                        if (sh_nx == ref_pat) begin
                            vcnt_nx = vcnt + VW'(1);
                            if (vcnt_nx == VDONE) state_nx = LOCKED;
                        end else begin
                            // Re-phase onto the newest period and restart the count.
                            ref_nx   = sh_nx;
                            skips_nx = popcnt(sh_nx);
                            vcnt_nx  = VW'(1);
                        end
                    end
                end
                LOCKED: begin
                    mism = skip_r ^ ref_pat[pos];
                    if (mism) begin
                        err_nx = 1'b1;
                        if (errcnt != '1) errcnt_nx = errcnt + CNT_W'(1);
`ifdef SKIPRING_MON_STICKY_EN
                        sticky_nx[pos] = 1'b1;
`endif
                    end
                    if (last) begin
                        lcnt_nx = (bad | mism) ? lcnt + LW'(1) : '0;
                        bad_nx  = 1'b0;
                        if (lcnt_nx == LDONE) begin
                            state_nx = HUNT;
                            fill_nx  = '0;
                            vcnt_nx  = '0;
                            lcnt_nx  = '0;
                        end
                    end else begin
                        bad_nx = bad | mism;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    // State register for the FSM and its datapath.
    always_ff @(posedge iCLK or negedge nRST) begin
        if (!nRST) begin
            state   <= HUNT;
            sh      <= '0;
            ref_pat <= '0;
            skips   <= '0;
            pos     <= '0;
            fill    <= '0;
            phase   <= '0;
            vcnt    <= '0;
            lcnt    <= '0;
            bad     <= 1'b0;
            err     <= 1'b0;
            errcnt  <= '0;
`ifdef SKIPRING_MON_STICKY_EN
            sticky  <= '0;
`endif
        end else begin
            state   <= state_nx;
            sh      <= sh_nx;
            ref_pat <= ref_nx;
            skips   <= skips_nx;
            pos     <= pos_nx;
            fill    <= fill_nx;
            phase   <= phase_nx;
            vcnt    <= vcnt_nx;
            lcnt    <= lcnt_nx;
            bad     <= bad_nx;
            err     <= err_nx;
            errcnt  <= errcnt_nx;
`ifdef SKIPRING_MON_STICKY_EN
            sticky  <= sticky_nx;
`endif
        end
    end

    assign oMASK   = ref_pat;
    assign oPHASE  = phase;
    assign oLOCK   = (state == LOCKED);
    assign oERR    = err;
    assign oERRCNT = errcnt;
    assign oSKIPS  = skips;
`ifdef SKIPRING_MON_STICKY_EN
    assign oSTICKY = sticky;
`endif

endmodule
